// File: rtl/pipelined_madd.sv
// Four-stage unsigned a*b*c+d pipeline with valid/ready handshakes on both sides.
// Output backpressure stalls every stage at once; bubbles are carried, not squeezed out.
module pipelined_madd #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic [WIDTH-1:0]       c,
  input  logic [WIDTH-1:0]       d,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3*WIDTH:0]       out_data,
  output logic [COUNT_WIDTH-1:0] result_count,
  output logic                   busy
);

  localparam int unsigned RW = 3 * WIDTH + 1;

  logic en;
  logic accept;

  logic                   s0_valid_q, s0_valid_d;
  logic [WIDTH-1:0]       s0_a_q, s0_a_d, s0_b_q, s0_b_d, s0_c_q, s0_c_d, s0_d_q, s0_d_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [2*WIDTH-1:0]     s1_prod_q, s1_prod_d;
  logic [WIDTH-1:0]       s1_c_q, s1_c_d, s1_d_q, s1_d_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [3*WIDTH-1:0]     s2_prod_q, s2_prod_d;
  logic [WIDTH-1:0]       s2_d_q, s2_d_d;
  logic                   out_valid_q, out_valid_d;
  logic [RW-1:0]          out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  assign en       = !out_valid_q || out_ready;
  assign accept   = in_valid && en;
  assign in_ready = en;

  always_comb begin
    s0_valid_d  = s0_valid_q;
    s0_a_d      = s0_a_q;
    s0_b_d      = s0_b_q;
    s0_c_d      = s0_c_q;
    s0_d_d      = s0_d_q;
    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    s1_c_d      = s1_c_q;
    s1_d_d      = s1_d_q;
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_d_d      = s2_d_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;

    if (en) begin
      // Data registers load freely; only the valid bits qualify them.
      s0_valid_d  = accept;
      s0_a_d      = a;
      s0_b_d      = b;
      s0_c_d      = c;
      s0_d_d      = d;
      s1_valid_d  = s0_valid_q;
      s1_prod_d   = {{WIDTH{1'b0}}, s0_a_q} * {{WIDTH{1'b0}}, s0_b_q};
      s1_c_d      = s0_c_q;
      s1_d_d      = s0_d_q;
      s2_valid_d  = s1_valid_q;
      s2_prod_d   = {{WIDTH{1'b0}}, s1_prod_q} * {{(2*WIDTH){1'b0}}, s1_c_q};
      s2_d_d      = s1_d_q;
      out_valid_d = s2_valid_q;
      // A bubble must not clobber the last delivered result.
      if (s2_valid_q) begin
        out_data_d = {1'b0, s2_prod_q} + {{(2*WIDTH+1){1'b0}}, s2_d_q};
      end
    end

    if (out_valid_q && out_ready) begin
      count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q  <= 1'b0;
      s0_a_q      <= '0;
      s0_b_q      <= '0;
      s0_c_q      <= '0;
      s0_d_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_c_q      <= '0;
      s1_d_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_d_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_a_q      <= s0_a_d;
      s0_b_q      <= s0_b_d;
      s0_c_q      <= s0_c_d;
      s0_d_q      <= s0_d_d;
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_c_q      <= s1_c_d;
      s1_d_q      <= s1_d_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_d_q      <= s2_d_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign result_count = count_q;
  assign busy         = s0_valid_q || s1_valid_q || s2_valid_q || out_valid_q;

endmodule
